// File: rtl/fifo_rd_drain_pkg.sv
// Shared constants and types for the FIFO read-side drain block.
// Width helpers keep occupancy able to represent a completely full buffer.
package fifo_rd_drain_pkg;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int BUF_DEPTH_DEF  = 3;

    // Debug view of the read pipeline, derived from occupancy and the pending-read flag.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FULL  = 2'd3
    } drain_state_t;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_rd_elastic_buf.sv
// Purpose: circular elastic buffer holding words read back from the FIFO.
// Latency: a pushed word becomes the head one cycle after the push.
// Backpressure: pop is ignored when empty; the caller must never push into a full buffer.
module fifo_rd_elastic_buf
    import fifo_rd_drain_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH_DEF,
    parameter int DEPTH = BUF_DEPTH_DEF,
    parameter int OCC_W = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [OCC_W-1:0] occ,
    output logic [WIDTH-1:0] head_data,
    output logic             head_vld
);

    localparam int PTR_W = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign pop_ok    = pop && (occ != '0);
    assign head_vld  = (occ != '0);
    assign head_data = mem[head_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            occ      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[tail_ptr] <= push_data;
                tail_ptr      <= ptr_inc(tail_ptr);
            end
            if (pop_ok) begin
                head_ptr <= ptr_inc(head_ptr);
            end
            case ({push, pop_ok})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Reads are only issued with a free slot reserved, so this can only fire on a logic bug.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop_ok && (occ == OCC_W'(DEPTH))));
        end
    end

endmodule

// File: rtl/fifo_rd_drain.sv
// Purpose: read master for the project FIFO, re-presenting words on a valid/ready stream.
// Latency: rd_en in cycle N gives m_valid in N+2; one word per cycle when the sink is ready.
// Backpressure: rd_en stops once buffered plus in-flight words fill BUF_DEPTH. Option: FIFO_RD_STATS_EN.
module fifo_rd_drain
    import fifo_rd_drain_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int BUF_DEPTH  = BUF_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  empty,
    input  logic [FIFO_WIDTH-1:0] data_out,
    input  logic                  underflow,
    output logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  proto_err
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [31:0]           rd_count
`endif
);

    localparam int OCC_W = occ_width(BUF_DEPTH);

    logic [OCC_W-1:0] occ;
    logic [OCC_W:0]   inflight;
    logic             pend;
    logic             push;
    logic             pop;
    drain_state_t     state;

    assign inflight = {1'b0, occ} + {{OCC_W{1'b0}}, pend};

    always_comb begin
        state = IDLE;
        if (inflight == (OCC_W + 1)'(BUF_DEPTH)) begin
            state = FULL;
        end else if (pend) begin
            state = FETCH;
        end else if (occ != '0) begin
            state = HOLD;
        end
    end

    // A read is only issued when a buffer slot is guaranteed for its return, so m_ready never gates rd_en.
    assign rd_en = !rst && !empty && (state != FULL);
    assign push  = pend && !underflow;
    assign pop   = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend      <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            pend <= rd_en;
            if (pend && underflow) begin
                proto_err <= 1'b1;
            end
        end
    end

    fifo_rd_elastic_buf #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (BUF_DEPTH),
        .OCC_W (OCC_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (data_out),
        .pop       (pop),
        .occ       (occ),
        .head_data (m_data),
        .head_vld  (m_valid)
    );

`ifdef FIFO_RD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
        end else if (pop) begin
            rd_count <= rd_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: behavioural FIFO on the read port, scoreboard on the stream side.
module tb_fifo_rd_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic        empty;
    logic [15:0] data_out;
    logic        underflow;
    logic        rd_en;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        proto_err;
`ifdef FIFO_RD_STATS_EN
    logic [31:0] rd_count;
`endif

    always #5 clk = ~clk;

    fifo_rd_drain #(
        .FIFO_WIDTH (16),
        .BUF_DEPTH  (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .empty     (empty),
        .data_out  (data_out),
        .underflow (underflow),
        .rd_en     (rd_en),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .proto_err (proto_err)
`ifdef FIFO_RD_STATS_EN
        ,
        .rd_count  (rd_count)
`endif
    );

    logic [15:0] fq[$];
    logic [15:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int cnum = 0;
    int nrd, npop, first_rd, last_rd, first_pop, last_pop;
    bit rd_s, ret_vld, force_uf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clr_stats();
        nrd = 0; npop = 0; first_rd = -1; last_rd = -1; first_pop = -1; last_pop = -1;
    endtask

    task automatic load(input int base, input int n);
        for (int i = 0; i < n; i++) fq.push_back(16'(base + i));
        empty = (fq.size() == 0);
    endtask

    // One clock: score the stream at negedge, then play the FIFO's registered read response.
    task automatic cyc();
        @(negedge clk);
        cnum++;
        rd_s = rd_en;
        if (rd_s) begin
            if (first_rd < 0) first_rd = cnum;
            last_rd = cnum;
            nrd++;
        end
        if (rst) begin
            exp_q.delete();
        end else begin
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_word", 32'(m_valid), 32'd0);
                end else begin
                    check("sb_head_data", 32'(m_data), 32'(exp_q[0]));
                    if (m_ready) void'(exp_q.pop_front());
                end
                if (m_ready) begin
                    if (first_pop < 0) first_pop = cnum;
                    last_pop = cnum;
                    npop++;
                end
            end
            if (ret_vld && !underflow) exp_q.push_back(data_out);
        end
        @(posedge clk);
        #1;
        ret_vld   = rd_s;
        underflow = 1'b0;
        data_out  = 16'hDEAD;
        if (rd_s) begin
            if (fq.size() == 0) begin
                underflow = 1'b1;
            end else begin
                data_out = fq.pop_front();
                if (force_uf) begin
                    underflow = 1'b1;
                    force_uf  = 1'b0;
                end
            end
        end
        empty = (fq.size() == 0);
        #1;
    endtask

    initial begin
        rst = 1'b1; empty = 1'b1; data_out = '0; underflow = 1'b0; m_ready = 1'b0;
        ret_vld = 1'b0; force_uf = 1'b0;
        clr_stats();

        // Reset values
        cyc();
        cyc();
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);
        rst = 1'b0;

        // Empty FIFO: nothing is read or presented
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("idle_rd_en", 32'(rd_en), 32'd0);
            check("idle_m_valid", 32'(m_valid), 32'd0);
            check("idle_proto_err", 32'(proto_err), 32'd0);
        end

        // Streaming at full rate
        clr_stats();
        m_ready = 1'b1;
        load(1, 8);
        for (int i = 0; i < 30; i++) cyc();
        check("stream_reads", 32'(nrd), 32'd8);
        check("stream_reads_back_to_back", 32'(last_rd - first_rd), 32'd7);
        check("stream_fill_latency", 32'(first_pop - first_rd), 32'd2);
        check("stream_words", 32'(npop), 32'd8);
        check("stream_words_back_to_back", 32'(last_pop - first_pop), 32'd7);
        check("stream_sb_drained", 32'(exp_q.size()), 32'd0);

        // Sink stalled: only BUF_DEPTH reads, head held stable
        clr_stats();
        m_ready = 1'b0;
        load(1, 8);
        for (int i = 0; i < 12; i++) cyc();
        check("stall_reads", 32'(nrd), 32'd3);
        check("stall_rd_en", 32'(rd_en), 32'd0);
        check("stall_m_valid", 32'(m_valid), 32'd1);
        check("stall_m_data", 32'(m_data), 32'h0001);
        check("stall_words", 32'(npop), 32'd0);
        m_ready = 1'b1;
        for (int i = 0; i < 25; i++) cyc();
        check("release_reads", 32'(nrd), 32'd8);
        check("release_words", 32'(npop), 32'd8);
        check("release_sb_drained", 32'(exp_q.size()), 32'd0);

        // Underflow on a returning read: word dropped, error sticky
        clr_stats();
        force_uf = 1'b1;
        load(16'h00AA, 1);
        for (int i = 0; i < 6; i++) cyc();
        check("uf_words", 32'(npop), 32'd0);
        check("uf_m_valid", 32'(m_valid), 32'd0);
        check("uf_proto_err", 32'(proto_err), 32'd1);
        load(16'h00BB, 1);
        for (int i = 0; i < 6; i++) cyc();
        check("uf_next_words", 32'(npop), 32'd1);
        check("uf_proto_err_sticky", 32'(proto_err), 32'd1);

        // Reset with two words buffered and one read in flight
        clr_stats();
        m_ready = 1'b0;
        load(16'h0100, 8);
        for (int i = 0; i < 20 && nrd < 3; i++) cyc();
        check("mid_rst_setup_reads", 32'(nrd), 32'd3);
        rst = 1'b1;
        fq.delete();
        empty = 1'b1;
        #1;
        check("mid_rst_rd_en", 32'(rd_en), 32'd0);
        cyc();
        rst = 1'b0;
        check("mid_rst_m_valid", 32'(m_valid), 32'd0);
        check("mid_rst_m_data", 32'(m_data), 32'd0);
        check("mid_rst_proto_err", 32'(proto_err), 32'd0);
        clr_stats();
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        check("mid_rst_no_delivery", 32'(npop), 32'd0);
        check("mid_rst_no_reads", 32'(nrd), 32'd0);

`ifdef FIFO_RD_STATS_EN
        // Delivered-word counter under random sink stalls
        clr_stats();
        load(16'h0200, 5);
        for (int i = 0; i < 80 && npop < 5; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        m_ready = 1'b0;
        check("stats_words", 32'(npop), 32'd5);
        check("stats_rd_count", rd_count, 32'd5);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("stats_rd_count_rst", rd_count, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
